// File: rtl/l1i_nway_cache_control.sv
// Control FSM for an N-way set-associative, read-only L1 instruction cache.
// Handles hit service, miss fetch/fill sequencing, tree-PLRU updates and hit/miss statistics.
module l1i_nway_cache_control #(
    parameter int NUM_WAYS = 2,
    parameter int COUNT_W  = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                mem_read,
    output logic                mem_resp,
    input  logic [NUM_WAYS-1:0] hit_vec,
    input  logic [NUM_WAYS-1:0] valid_vec,
    input  logic [NUM_WAYS-2:0] plru_out,
    output logic [NUM_WAYS-2:0] plru_in,
    output logic                plru_W,
    output logic [NUM_WAYS-1:0] way_W,
    output logic                load_mar,
    output logic                load_mdr,
    output logic                addr_mux_sel,
    output logic                pmem_read,
    input  logic                pmem_resp,
    input  logic                hit_clear,
    input  logic                miss_clear,
    output logic [COUNT_W-1:0]  hit_count,
    output logic [COUNT_W-1:0]  miss_count
);

    localparam int WAY_W = $clog2(NUM_WAYS);
    localparam int NODES = NUM_WAYS - 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        FILL  = 2'd2
    } state_t;

    state_t             state_reg, state_next;
    logic [WAY_W-1:0]   victim_q_reg, victim_q_next;
    logic [COUNT_W-1:0] hit_count_reg, hit_count_next;
    logic [COUNT_W-1:0] miss_count_reg, miss_count_next;

    logic [WAY_W-1:0]   hit_way;
    logic [WAY_W-1:0]   invalid_way;
    logic               invalid_found;
    logic [WAY_W-1:0]   victim;
    logic               hit_inc;
    logic               miss_inc;

    // Walk the heap-ordered tree from the root: bit 0 descends left, bit 1 right.
    function automatic logic [WAY_W-1:0] plru_victim(input logic [NODES-1:0] bits);
        int               idx;
        logic [NODES-1:0] sh;
        idx = 0;
        for (int lvl = 0; lvl < WAY_W; lvl++) begin
            sh  = bits >> idx;
            idx = sh[0] ? (2 * idx + 2) : (2 * idx + 1);
        end
        return WAY_W'(idx - NODES);
    endfunction

    // Climb from the touched leaf, pointing each ancestor at the sibling subtree.
    function automatic logic [NODES-1:0] plru_touch(input logic [NODES-1:0] bits,
                                                    input logic [WAY_W-1:0] way);
        logic [NODES-1:0] res;
        logic [NODES-1:0] mask;
        int               node;
        int               parent;
        res  = bits;
        node = NODES + int'(way);
        for (int lvl = 0; lvl < WAY_W; lvl++) begin
            parent = (node - 1) / 2;
            mask   = NODES'(1) << parent;
            if ((node % 2) == 1) begin
                res = res | mask;
            end else begin
                res = res & ~mask;
            end
            node = parent;
        end
        return res;
    endfunction

    always_comb begin
        hit_way = '0;
        for (int i = 0; i < NUM_WAYS; i++) begin
            if (hit_vec[i]) begin
                hit_way = WAY_W'(i);
            end
        end
    end

    // Scanning downwards leaves the lowest-index invalid way as the final pick.
    always_comb begin
        invalid_found = 1'b0;
        invalid_way   = '0;
        for (int i = NUM_WAYS - 1; i >= 0; i--) begin
            if (!valid_vec[i]) begin
                invalid_found = 1'b1;
                invalid_way   = WAY_W'(i);
            end
        end
    end

    assign victim = invalid_found ? invalid_way : plru_victim(plru_out);

    always_comb begin
        state_next    = state_reg;
        victim_q_next = victim_q_reg;
        mem_resp      = 1'b0;
        plru_W        = 1'b0;
        plru_in       = '0;
        load_mar      = 1'b0;
        load_mdr      = 1'b0;
        addr_mux_sel  = 1'b0;
        pmem_read     = 1'b0;
        hit_inc       = 1'b0;
        miss_inc      = 1'b0;
        case (state_reg)
            IDLE: begin
                if (mem_read) begin
                    if (|hit_vec) begin
                        mem_resp = 1'b1;
                        plru_W   = 1'b1;
                        plru_in  = plru_touch(plru_out, hit_way);
                        hit_inc  = 1'b1;
                    end else begin
                        load_mar      = 1'b1;
                        victim_q_next = victim;
                        state_next    = FETCH;
                    end
                end
            end
            FETCH: begin
                pmem_read    = 1'b1;
                addr_mux_sel = 1'b1;
                if (pmem_resp) begin
                    load_mdr   = 1'b1;
                    state_next = FILL;
                end
            end
            FILL: begin
                // Completes even if the requester has gone away; the next IDLE lookup serves it.
                addr_mux_sel = 1'b1;
                plru_W       = 1'b1;
                plru_in      = plru_touch(plru_out, victim_q_reg);
                miss_inc     = 1'b1;
                state_next   = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    generate
        for (genvar gi = 0; gi < NUM_WAYS; gi++) begin : g_way_we
            assign way_W[gi] = (state_reg == FILL) && (victim_q_reg == WAY_W'(gi));
        end
    endgenerate

    // Clear beats a same-cycle increment; increments stop at all-ones.
    always_comb begin
        hit_count_next  = hit_count_reg;
        miss_count_next = miss_count_reg;
        if (hit_clear) begin
            hit_count_next = '0;
        end else if (hit_inc && (hit_count_reg != '1)) begin
            hit_count_next = hit_count_reg + COUNT_W'(1);
        end
        if (miss_clear) begin
            miss_count_next = '0;
        end else if (miss_inc && (miss_count_reg != '1)) begin
            miss_count_next = miss_count_reg + COUNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            victim_q_reg   <= '0;
            hit_count_reg  <= '0;
            miss_count_reg <= '0;
        end else begin
            state_reg      <= state_next;
            victim_q_reg   <= victim_q_next;
            hit_count_reg  <= hit_count_next;
            miss_count_reg <= miss_count_next;
        end
    end

    assign hit_count  = hit_count_reg;
    assign miss_count = miss_count_reg;

    hit_onehot_check: assert property (@(posedge clk) disable iff (rst)
        mem_read |-> $onehot0(hit_vec));

endmodule

// File: tb/tb_l1i_nway_cache_control.sv
// Directed bench for l1i_nway_cache_control: a 4-way/32-bit-counter instance and a
// 2-way/4-bit-counter instance, with hand-derived expected values.
module tb_l1i_nway_cache_control;

    logic clk;
    logic rst;
    int   tests_run;
    int   tests_failed;

    // 4-way instance
    logic        a_mem_read, a_mem_resp, a_plru_W, a_load_mar, a_load_mdr;
    logic        a_addr_mux_sel, a_pmem_read, a_pmem_resp, a_hit_clear, a_miss_clear;
    logic [3:0]  a_hit_vec, a_valid_vec, a_way_W;
    logic [2:0]  a_plru_out, a_plru_in;
    logic [31:0] a_hit_count, a_miss_count;

    // 2-way instance
    logic        b_mem_read, b_mem_resp, b_plru_W, b_load_mar, b_load_mdr;
    logic        b_addr_mux_sel, b_pmem_read, b_pmem_resp, b_hit_clear, b_miss_clear;
    logic [1:0]  b_hit_vec, b_valid_vec, b_way_W;
    logic [0:0]  b_plru_out, b_plru_in;
    logic [3:0]  b_hit_count, b_miss_count;

    l1i_nway_cache_control #(.NUM_WAYS(4), .COUNT_W(32)) dut_a (
        .clk(clk), .rst(rst), .mem_read(a_mem_read), .mem_resp(a_mem_resp),
        .hit_vec(a_hit_vec), .valid_vec(a_valid_vec), .plru_out(a_plru_out),
        .plru_in(a_plru_in), .plru_W(a_plru_W), .way_W(a_way_W),
        .load_mar(a_load_mar), .load_mdr(a_load_mdr), .addr_mux_sel(a_addr_mux_sel),
        .pmem_read(a_pmem_read), .pmem_resp(a_pmem_resp), .hit_clear(a_hit_clear),
        .miss_clear(a_miss_clear), .hit_count(a_hit_count), .miss_count(a_miss_count)
    );

    l1i_nway_cache_control #(.NUM_WAYS(2), .COUNT_W(4)) dut_b (
        .clk(clk), .rst(rst), .mem_read(b_mem_read), .mem_resp(b_mem_resp),
        .hit_vec(b_hit_vec), .valid_vec(b_valid_vec), .plru_out(b_plru_out),
        .plru_in(b_plru_in), .plru_W(b_plru_W), .way_W(b_way_W),
        .load_mar(b_load_mar), .load_mdr(b_load_mdr), .addr_mux_sel(b_addr_mux_sel),
        .pmem_read(b_pmem_read), .pmem_resp(b_pmem_resp), .hit_clear(b_hit_clear),
        .miss_clear(b_miss_clear), .hit_count(b_hit_count), .miss_count(b_miss_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        tests_run++;
        if (a_hit_count !== 32'd0 || a_miss_count !== 32'd0) begin
            tests_failed++;
            $display("FAIL reset_counters_a: got hit=%0d miss=%0d want 0/0", a_hit_count, a_miss_count);
        end
        tests_run++;
        if (b_hit_count !== 4'd0 || b_miss_count !== 4'd0) begin
            tests_failed++;
            $display("FAIL reset_counters_b: got hit=%0d miss=%0d want 0/0", b_hit_count, b_miss_count);
        end
        tests_run++;
        if ({a_pmem_read, a_mem_resp, a_plru_W, a_way_W, a_load_mar, a_addr_mux_sel} !== 9'd0) begin
            tests_failed++;
            $display("FAIL reset_strobes_a: got pmem_read=%b mem_resp=%b plru_W=%b way_W=%b load_mar=%b sel=%b want all 0",
                     a_pmem_read, a_mem_resp, a_plru_W, a_way_W, a_load_mar, a_addr_mux_sel);
        end
        $display("[TB] test_reset done");
    endtask

    // valid=0111 picks way3; pmem answers on the 5th FETCH cycle.
    task automatic test_miss_invalid_way();
        @(negedge clk);
        a_mem_read = 1'b1; a_hit_vec = 4'b0000; a_valid_vec = 4'b0111; a_plru_out = 3'b000;
        #1;
        tests_run++;
        if (a_load_mar !== 1'b1 || a_pmem_read !== 1'b0) begin
            tests_failed++;
            $display("FAIL miss_t0: got load_mar=%b pmem_read=%b want 1/0", a_load_mar, a_pmem_read);
        end
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            a_pmem_resp = (k == 5);
            #1;
            tests_run++;
            if (a_pmem_read !== 1'b1 || a_addr_mux_sel !== 1'b1 || a_load_mdr !== (k == 5)) begin
                tests_failed++;
                $display("FAIL miss_fetch_t%0d: got pmem_read=%b sel=%b load_mdr=%b want 1/1/%b",
                         k, a_pmem_read, a_addr_mux_sel, a_load_mdr, (k == 5));
            end
        end
        @(negedge clk);
        a_pmem_resp = 1'b0; a_valid_vec = 4'b1111;
        #1;
        tests_run++;
        if (a_way_W !== 4'b1000 || a_plru_W !== 1'b1 || a_plru_in !== 3'b000 || a_pmem_read !== 1'b0) begin
            tests_failed++;
            $display("FAIL miss_fill_t6: got way_W=%b plru_W=%b plru_in=%b pmem_read=%b want 1000/1/000/0",
                     a_way_W, a_plru_W, a_plru_in, a_pmem_read);
        end
        @(negedge clk);
        a_hit_vec = 4'b1000;
        #1;
        tests_run++;
        if (a_mem_resp !== 1'b1 || a_miss_count !== 32'd1) begin
            tests_failed++;
            $display("FAIL miss_hit_t7: got mem_resp=%b miss_count=%0d want 1/1", a_mem_resp, a_miss_count);
        end
        @(negedge clk);
        a_mem_read = 1'b0; a_hit_vec = 4'b0000;
        #1;
        tests_run++;
        if (a_hit_count !== 32'd1 || a_mem_resp !== 1'b0) begin
            tests_failed++;
            $display("FAIL miss_after: got hit_count=%0d mem_resp=%b want 1/0", a_hit_count, a_mem_resp);
        end
        $display("[TB] test_miss_invalid_way done");
    endtask

    // All valid, plru=000 -> way0; touch(way0) on 000 sets nodes 0,1 -> 011.
    // Then touch(way3) on 011 clears nodes 0,2 and keeps node1 -> 010.
    task automatic test_plru_victim();
        @(negedge clk);
        a_mem_read = 1'b1; a_hit_vec = 4'b0000; a_valid_vec = 4'b1111; a_plru_out = 3'b000;
        #1;
        tests_run++;
        if (a_load_mar !== 1'b1) begin
            tests_failed++;
            $display("FAIL plru_miss_t0: got load_mar=%b want 1", a_load_mar);
        end
        @(negedge clk);
        a_pmem_resp = 1'b1;
        #1;
        @(negedge clk);
        a_pmem_resp = 1'b0;
        #1;
        tests_run++;
        if (a_way_W !== 4'b0001 || a_plru_in !== 3'b011 || a_plru_W !== 1'b1) begin
            tests_failed++;
            $display("FAIL plru_fill: got way_W=%b plru_in=%b plru_W=%b want 0001/011/1", a_way_W, a_plru_in, a_plru_W);
        end
        @(negedge clk);
        a_hit_vec = 4'b1000; a_plru_out = 3'b011;
        #1;
        tests_run++;
        if (a_mem_resp !== 1'b1 || a_plru_W !== 1'b1 || a_plru_in !== 3'b010) begin
            tests_failed++;
            $display("FAIL plru_hit_way3: got mem_resp=%b plru_W=%b plru_in=%b want 1/1/010", a_mem_resp, a_plru_W, a_plru_in);
        end
        @(negedge clk);
        a_mem_read = 1'b0; a_hit_vec = 4'b0000;
        #1;
        tests_run++;
        if (a_hit_count !== 32'd2 || a_miss_count !== 32'd2) begin
            tests_failed++;
            $display("FAIL plru_counts: got hit=%0d miss=%0d want 2/2", a_hit_count, a_miss_count);
        end
        $display("[TB] test_plru_victim done");
    endtask

    // Requester leaves during FETCH; plru=111 walks right twice -> way3.
    task automatic test_drop_in_fetch();
        @(negedge clk);
        a_mem_read = 1'b1; a_valid_vec = 4'b1111; a_plru_out = 3'b111;
        #1;
        @(negedge clk);
        a_mem_read = 1'b0; a_pmem_resp = 1'b1;
        #1;
        @(negedge clk);
        a_pmem_resp = 1'b0;
        #1;
        tests_run++;
        if (a_way_W !== 4'b1000 || a_mem_resp !== 1'b0) begin
            tests_failed++;
            $display("FAIL drop_fill: got way_W=%b mem_resp=%b want 1000/0", a_way_W, a_mem_resp);
        end
        @(negedge clk);
        #1;
        tests_run++;
        if (a_mem_resp !== 1'b0 || a_miss_count !== 32'd3 || a_hit_count !== 32'd2) begin
            tests_failed++;
            $display("FAIL drop_after: got mem_resp=%b miss=%0d hit=%0d want 0/3/2", a_mem_resp, a_miss_count, a_hit_count);
        end
        $display("[TB] test_drop_in_fetch done");
    endtask

    task automatic test_two_way_hit();
        @(negedge clk);
        b_mem_read = 1'b1; b_hit_vec = 2'b01; b_valid_vec = 2'b11; b_plru_out = 1'b0;
        #1;
        tests_run++;
        if (b_mem_resp !== 1'b1 || b_plru_W !== 1'b1 || b_plru_in !== 1'b1 || b_hit_count !== 4'd0) begin
            tests_failed++;
            $display("FAIL two_way_hit: got mem_resp=%b plru_W=%b plru_in=%b hit=%0d want 1/1/1/0",
                     b_mem_resp, b_plru_W, b_plru_in, b_hit_count);
        end
        @(negedge clk);
        b_mem_read = 1'b0; b_hit_vec = 2'b00;
        #1;
        tests_run++;
        if (b_hit_count !== 4'd1) begin
            tests_failed++;
            $display("FAIL two_way_hit_count: got %0d want 1", b_hit_count);
        end
        $display("[TB] test_two_way_hit done");
    endtask

    // plru_out=1 selects way1; touching way1 writes 0.
    task automatic test_two_way_victim();
        @(negedge clk);
        b_mem_read = 1'b1; b_hit_vec = 2'b00; b_valid_vec = 2'b11; b_plru_out = 1'b1;
        #1;
        @(negedge clk);
        b_pmem_resp = 1'b1;
        #1;
        @(negedge clk);
        b_pmem_resp = 1'b0; b_mem_read = 1'b0;
        #1;
        tests_run++;
        if (b_way_W !== 2'b10 || b_plru_in !== 1'b0 || b_plru_W !== 1'b1) begin
            tests_failed++;
            $display("FAIL two_way_fill: got way_W=%b plru_in=%b plru_W=%b want 10/0/1", b_way_W, b_plru_in, b_plru_W);
        end
        $display("[TB] test_two_way_victim done");
    endtask

    task automatic test_saturation();
        @(negedge clk);
        b_mem_read = 1'b1; b_hit_vec = 2'b10; b_plru_out = 1'b0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
        end
        #1;
        tests_run++;
        if (b_hit_count !== 4'hF) begin
            tests_failed++;
            $display("FAIL sat_hold: got %0h want f", b_hit_count);
        end
        b_hit_clear = 1'b1;
        @(negedge clk);
        b_hit_clear = 1'b0; b_mem_read = 1'b0; b_hit_vec = 2'b00; b_miss_clear = 1'b1;
        #1;
        tests_run++;
        if (b_hit_count !== 4'h0 || b_miss_count !== 4'd1) begin
            tests_failed++;
            $display("FAIL sat_clear: got hit=%0h miss=%0d want 0/1", b_hit_count, b_miss_count);
        end
        @(negedge clk);
        b_miss_clear = 1'b0;
        #1;
        tests_run++;
        if (b_miss_count !== 4'd0) begin
            tests_failed++;
            $display("FAIL miss_clear: got %0d want 0", b_miss_count);
        end
        $display("[TB] test_saturation done");
    endtask

    task automatic test_reset_mid_miss();
        @(negedge clk);
        a_mem_read = 1'b1; a_hit_vec = 4'b0000; a_valid_vec = 4'b1111; a_plru_out = 3'b000;
        #1;
        @(negedge clk);
        a_mem_read = 1'b0;
        #1;
        @(negedge clk);
        rst = 1'b1;
        #1;
        tests_run++;
        if (a_pmem_read !== 1'b1) begin
            tests_failed++;
            $display("FAIL rst_fetch2: got pmem_read=%b want 1", a_pmem_read);
        end
        @(negedge clk);
        rst = 1'b0; a_pmem_resp = 1'b1;
        #1;
        tests_run++;
        if (a_pmem_read !== 1'b0 || a_load_mdr !== 1'b0 || a_way_W !== 4'b0000 || a_plru_W !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_idle: got pmem_read=%b load_mdr=%b way_W=%b plru_W=%b want 0/0/0000/0",
                     a_pmem_read, a_load_mdr, a_way_W, a_plru_W);
        end
        @(negedge clk);
        a_pmem_resp = 1'b0;
        #1;
        tests_run++;
        if (a_way_W !== 4'b0000 || a_plru_W !== 1'b0 || a_hit_count !== 32'd0 || a_miss_count !== 32'd0) begin
            tests_failed++;
            $display("FAIL rst_after: got way_W=%b plru_W=%b hit=%0d miss=%0d want 0000/0/0/0",
                     a_way_W, a_plru_W, a_hit_count, a_miss_count);
        end
        $display("[TB] test_reset_mid_miss done");
    endtask

    initial begin
        tests_run = 0; tests_failed = 0;
        rst = 1'b1;
        a_mem_read = 1'b0; a_hit_vec = '0; a_valid_vec = '0; a_plru_out = '0;
        a_pmem_resp = 1'b0; a_hit_clear = 1'b0; a_miss_clear = 1'b0;
        b_mem_read = 1'b0; b_hit_vec = '0; b_valid_vec = '0; b_plru_out = '0;
        b_pmem_resp = 1'b0; b_hit_clear = 1'b0; b_miss_clear = 1'b0;
        test_reset();
        test_miss_invalid_way();
        test_plru_victim();
        test_drop_in_fetch();
        test_two_way_hit();
        test_two_way_victim();
        test_saturation();
        test_reset_mid_miss();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
